// File: rtl/ctrl_pipe_hazard_if.sv
// Control-decoder bus: IF/ID instruction fields and EX feedback in,
// per-stage control bundle and hazard signals out.
interface ctrl_pipe_hazard_if #(
    parameter int ALUCTRL_W = 5,
    parameter int ALUSRC_W  = 5,
    parameter int REG_W     = 5
);
    logic                 id_valid;
    logic [5:0]           id_opcode;
    logic [5:0]           id_func;
    logic [REG_W-1:0]     id_rs;
    logic [REG_W-1:0]     id_rt;
    logic [REG_W-1:0]     id_rd;
    logic                 ex_branch_taken;

    logic                 stall;
    logic                 flush_ifid;
    logic [ALUCTRL_W-1:0] ex_alu_ctrl;
    logic [ALUSRC_W-1:0]  ex_alu_src;
    logic                 ex_beq;
    logic                 ex_bne;
    logic                 ex_jump;
    logic [REG_W-1:0]     ex_dst;
    logic                 mem_write_en;
    logic                 mem_read;
    logic                 wb_reg_write_en;
    logic                 wb_mem2reg;
    logic [REG_W-1:0]     wb_dst;
    logic                 illegal;
    logic                 halted;

    modport master (
        output id_valid, id_opcode, id_func, id_rs, id_rt, id_rd, ex_branch_taken,
        input  stall, flush_ifid, ex_alu_ctrl, ex_alu_src, ex_beq, ex_bne, ex_jump,
               ex_dst, mem_write_en, mem_read, wb_reg_write_en, wb_mem2reg, wb_dst,
               illegal, halted
    );

    modport slave (
        input  id_valid, id_opcode, id_func, id_rs, id_rt, id_rd, ex_branch_taken,
        output stall, flush_ifid, ex_alu_ctrl, ex_alu_src, ex_beq, ex_bne, ex_jump,
               ex_dst, mem_write_en, mem_read, wb_reg_write_en, wb_mem2reg, wb_dst,
               illegal, halted
    );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// Pipelined main control: ID decode, ID/EX -> EX/MEM -> MEM/WB control
// registers, load-use stall, taken-branch flush and sticky STOP halt.
module ctrl_pipe_hazard #(
    parameter int ALUCTRL_W     = 5,
    parameter int ALUSRC_W      = 5,
    parameter int REG_W         = 5,
    parameter bit LOAD_STALL_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    ctrl_pipe_hazard_if.slave bus
);
    typedef struct packed {
        logic [ALUCTRL_W-1:0] alu_ctrl;
        logic [ALUSRC_W-1:0]  alu_src;
        logic                 beq;
        logic                 bne;
        logic                 jump;
        logic                 mem_write;
        logic                 mem_read;
        logic                 reg_write;
        logic                 mem2reg;
        logic                 stop;
        logic [REG_W-1:0]     dst;
    } ex_ctrl_t;

    typedef struct packed {
        logic             mem_write;
        logic             mem_read;
        logic             reg_write;
        logic             mem2reg;
        logic             stop;
        logic [REG_W-1:0] dst;
    } mem_ctrl_t;

    typedef struct packed {
        logic             reg_write;
        logic             mem2reg;
        logic             stop;
        logic [REG_W-1:0] dst;
    } wb_ctrl_t;

    ex_ctrl_t  r_ex;
    mem_ctrl_t r_mem;
    wb_ctrl_t  r_wb;
    logic      r_stop_seen;
    logic      r_halted;

    ex_ctrl_t  w_dec;
    ex_ctrl_t  w_ex_next;
    logic      w_undef;
    logic      w_rt_src;
    logic      w_load_use;
    logic      w_flush;

    // ID decode; undefined encodings and invalid slots collapse to a bubble
    always_comb begin
        w_dec    = '0;
        w_undef  = 1'b0;
        w_rt_src = 1'b0;
        case (bus.id_opcode)
            6'd0: begin
                w_dec.reg_write = 1'b1;
                w_dec.dst       = bus.id_rd;
                w_rt_src        = 1'b1;
                case (bus.id_func)
                    6'd0:  begin w_dec.alu_ctrl = ALUCTRL_W'(7); w_dec.alu_src = ALUSRC_W'(4); end
                    6'd2:  begin w_dec.alu_ctrl = ALUCTRL_W'(8); w_dec.alu_src = ALUSRC_W'(4); end
                    6'd3:  begin w_dec.alu_ctrl = ALUCTRL_W'(9); w_dec.alu_src = ALUSRC_W'(4); end
                    6'd4:  begin w_dec.alu_ctrl = ALUCTRL_W'(7); w_dec.alu_src = ALUSRC_W'(3); end
                    6'd6:  begin w_dec.alu_ctrl = ALUCTRL_W'(8); w_dec.alu_src = ALUSRC_W'(3); end
                    6'd7:  begin w_dec.alu_ctrl = ALUCTRL_W'(9); w_dec.alu_src = ALUSRC_W'(3); end
                    6'd32, 6'd33: w_dec.alu_ctrl = ALUCTRL_W'(0);
                    6'd34, 6'd35: w_dec.alu_ctrl = ALUCTRL_W'(1);
                    6'd36: w_dec.alu_ctrl = ALUCTRL_W'(2);
                    6'd37: w_dec.alu_ctrl = ALUCTRL_W'(3);
                    6'd38: w_dec.alu_ctrl = ALUCTRL_W'(4);
                    6'd39: w_dec.alu_ctrl = ALUCTRL_W'(5);
                    6'd42: w_dec.alu_ctrl = ALUCTRL_W'(6);
                    6'd8: begin
                        w_dec.jump      = 1'b1;
                        w_dec.reg_write = 1'b0;
                        w_dec.dst       = '0;
                    end
                    default: w_undef = 1'b1;
                endcase
            end
            6'd4, 6'd5: begin
                w_dec.beq      = (bus.id_opcode == 6'd4);
                w_dec.bne      = (bus.id_opcode == 6'd5);
                w_dec.alu_ctrl = ALUCTRL_W'(1);
                w_rt_src       = 1'b1;
            end
            6'd8, 6'd9: begin
                w_dec.alu_src   = ALUSRC_W'(2);
                w_dec.reg_write = 1'b1;
                w_dec.dst       = bus.id_rt;
            end
            6'd12, 6'd13, 6'd14: begin
                w_dec.alu_ctrl  = ALUCTRL_W'(bus.id_opcode - 6'd10);
                w_dec.alu_src   = ALUSRC_W'(1);
                w_dec.reg_write = 1'b1;
                w_dec.dst       = bus.id_rt;
            end
            6'd35: begin
                w_dec.alu_src   = ALUSRC_W'(2);
                w_dec.mem_read  = 1'b1;
                w_dec.mem2reg   = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.dst       = bus.id_rt;
            end
            6'd43: begin
                w_dec.alu_src   = ALUSRC_W'(2);
                w_dec.mem_write = 1'b1;
                w_rt_src        = 1'b1;
            end
            6'd2:  w_dec.jump = 1'b1;
            6'd3: begin
                w_dec.jump      = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.dst       = REG_W'(31);
            end
            6'd63: w_dec.stop = 1'b1;
            default: w_undef = 1'b1;
        endcase
        if (w_undef || !bus.id_valid) begin
            w_dec = '0;
        end
    end

    // Hazard detection; flush overrides the load-use stall
    always_comb begin
        w_flush    = bus.ex_branch_taken;
        w_load_use = LOAD_STALL_EN && r_ex.mem_read && (r_ex.dst != '0) && bus.id_valid &&
                     ((r_ex.dst == bus.id_rs) || ((r_ex.dst == bus.id_rt) && w_rt_src));
        w_ex_next  = w_dec;
        if (w_flush || w_load_use || r_stop_seen) begin
            w_ex_next = '0;
        end
    end

    // Stage registers shift every edge; the stop marker rides along to set halted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_stop_seen <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_ex        <= w_ex_next;
            r_mem       <= '{r_ex.mem_write, r_ex.mem_read, r_ex.reg_write,
                             r_ex.mem2reg, r_ex.stop, r_ex.dst};
            r_wb        <= '{r_mem.reg_write, r_mem.mem2reg, r_mem.stop, r_mem.dst};
            r_stop_seen <= r_stop_seen | (w_ex_next.stop);
            r_halted    <= r_halted | r_wb.stop;
        end
    end

    assign bus.stall           = rst_n && !w_flush && (r_halted || w_load_use);
    assign bus.flush_ifid      = rst_n && w_flush;
    assign bus.illegal         = bus.id_valid && w_undef;
    assign bus.halted          = r_halted;
    assign bus.ex_alu_ctrl     = r_ex.alu_ctrl;
    assign bus.ex_alu_src      = r_ex.alu_src;
    assign bus.ex_beq          = r_ex.beq;
    assign bus.ex_bne          = r_ex.bne;
    assign bus.ex_jump         = r_ex.jump;
    assign bus.ex_dst          = r_ex.dst;
    assign bus.mem_write_en    = r_mem.mem_write;
    assign bus.mem_read        = r_mem.mem_read;
    assign bus.wb_reg_write_en = r_wb.reg_write && (r_wb.dst != '0);
    assign bus.wb_mem2reg      = r_wb.mem2reg;
    assign bus.wb_dst          = r_wb.dst;
endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Scoreboard bench: each driven ID slot pushes its expected EX ALU op and
// expected WB result; the queues are popped as the slot reaches each stage.
module tb_ctrl_pipe_hazard;
    logic clk;
    logic rst_n;

    ctrl_pipe_hazard_if #(.ALUCTRL_W(5), .ALUSRC_W(5), .REG_W(5)) bus ();

    ctrl_pipe_hazard #(
        .ALUCTRL_W(5), .ALUSRC_W(5), .REG_W(5), .LOAD_STALL_EN(1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       v;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } instr_t;

    typedef struct packed {
        logic       we;
        logic [4:0] dst;
        logic       m2r;
    } wb_t;

    localparam instr_t NOP = '0;

    int  n_chk = 0;
    int  n_err = 0;
    int  ex_q[$];
    wb_t wb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic instr_t r_ins(input logic [5:0] fn, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd);
        return '{1'b1, 6'd0, fn, rs, rt, rd};
    endfunction

    function automatic instr_t i_ins(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt);
        return '{1'b1, op, 6'd0, rs, rt, 5'd0};
    endfunction

    task automatic drive(input instr_t in, input logic br);
        bus.id_valid        = in.v;
        bus.id_opcode       = in.op;
        bus.id_func         = in.fn;
        bus.id_rs           = in.rs;
        bus.id_rt           = in.rt;
        bus.id_rd           = in.rd;
        bus.ex_branch_taken = br;
    endtask

    task automatic prime();
        ex_q.delete();
        wb_q.delete();
        ex_q.push_back(0);
        repeat (3) wb_q.push_back('0);
    endtask

    // One ID slot: e_alu < 0 means the EX ALU op is not checked for this slot
    task automatic cyc(input instr_t in, input logic br, input logic e_stall,
                       input logic e_ill, input logic e_halt, input int e_alu,
                       input logic we, input logic [4:0] dst, input logic m2r);
        int  a;
        wb_t w;
        drive(in, br);
        #1;
        chk("stall",   32'(bus.stall),      32'(e_stall));
        chk("flush",   32'(bus.flush_ifid), 32'(br));
        chk("illegal", 32'(bus.illegal),    32'(e_ill));
        chk("halted",  32'(bus.halted),     32'(e_halt));
        a = ex_q.pop_front();
        if (a >= 0) chk("ex_alu", 32'(bus.ex_alu_ctrl), a);
        w = wb_q.pop_front();
        chk("wb_we",  32'(bus.wb_reg_write_en), 32'(w.we));
        chk("wb_m2r", 32'(bus.wb_mem2reg),      32'(w.m2r));
        if (w.we) chk("wb_dst", 32'(bus.wb_dst), 32'(w.dst));
        ex_q.push_back(e_alu);
        wb_q.push_back('{we, dst, m2r});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(NOP, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_halted", 32'(bus.halted),          32'd0);
        chk("rst_wb_we",  32'(bus.wb_reg_write_en), 32'd0);
        chk("rst_ex_alu", 32'(bus.ex_alu_ctrl),     32'd0);
        rst_n = 1'b1;
        prime();

        //  in                        br    stl   ill   hlt   alu  we    dst    m2r
        cyc(r_ins(6'd32, 1, 2, 3),   1'b0, 1'b0, 1'b0, 1'b0, 0,  1'b1, 5'd3,  1'b0); // ADD
        cyc(i_ins(6'd13, 1, 4),      1'b0, 1'b0, 1'b0, 1'b0, 3,  1'b1, 5'd4,  1'b0); // ORI
        cyc(i_ins(6'd35, 1, 5),      1'b0, 1'b0, 1'b0, 1'b0, 0,  1'b1, 5'd5,  1'b1); // LW r5
        cyc(r_ins(6'd32, 5, 6, 7),   1'b0, 1'b1, 1'b0, 1'b0, 0,  1'b0, 5'd0,  1'b0); // stalled
        cyc(r_ins(6'd32, 5, 6, 7),   1'b0, 1'b0, 1'b0, 1'b0, 0,  1'b1, 5'd7,  1'b0);
        cyc(i_ins(6'd35, 1, 0),      1'b0, 1'b0, 1'b0, 1'b0, 0,  1'b0, 5'd0,  1'b1); // LW r0
        cyc(r_ins(6'd32, 0, 0, 8),   1'b0, 1'b0, 1'b0, 1'b0, 0,  1'b1, 5'd8,  1'b0);
        cyc(i_ins(6'd35, 1, 11),     1'b0, 1'b0, 1'b0, 1'b0, 0,  1'b1, 5'd11, 1'b1); // LW r11
        cyc(i_ins(6'd43, 1, 11),     1'b0, 1'b1, 1'b0, 1'b0, 0,  1'b0, 5'd0,  1'b0); // SW rt use
        cyc(i_ins(6'd43, 1, 11),     1'b0, 1'b0, 1'b0, 1'b0, 0,  1'b0, 5'd0,  1'b0);
        cyc(i_ins(6'd35, 1, 12),     1'b0, 1'b0, 1'b0, 1'b0, 0,  1'b1, 5'd12, 1'b1); // LW r12
        cyc(i_ins(6'd8, 1, 12),      1'b0, 1'b0, 1'b0, 1'b0, 0,  1'b1, 5'd12, 1'b0); // ADDI no rt use
        cyc(i_ins(6'd4, 1, 2),       1'b0, 1'b0, 1'b0, 1'b0, 1,  1'b0, 5'd0,  1'b0); // BEQ
        cyc(r_ins(6'd32, 3, 4, 5),   1'b1, 1'b0, 1'b0, 1'b0, 0,  1'b0, 5'd0,  1'b0); // flushed
        cyc(i_ins(6'd35, 1, 9),      1'b0, 1'b0, 1'b0, 1'b0, 0,  1'b1, 5'd9,  1'b1); // LW r9
        cyc(r_ins(6'd32, 9, 2, 10),  1'b1, 1'b0, 1'b0, 1'b0, 0,  1'b0, 5'd0,  1'b0); // flush beats stall
        cyc(NOP,                     1'b0, 1'b0, 1'b0, 1'b0, 0,  1'b0, 5'd0,  1'b0);
        cyc(i_ins(6'd20, 1, 2),      1'b0, 1'b0, 1'b1, 1'b0, 0,  1'b0, 5'd0,  1'b0); // illegal op
        cyc('{1'b0, 6'd20, 6'd0, 5'd1, 5'd2, 5'd0},
                                     1'b0, 1'b0, 1'b0, 1'b0, 0,  1'b0, 5'd0,  1'b0); // invalid slot
        cyc(r_ins(6'd1, 1, 2, 3),    1'b0, 1'b0, 1'b1, 1'b0, 0,  1'b0, 5'd0,  1'b0); // illegal func
        cyc(i_ins(6'd3, 0, 0),       1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b1, 5'd31, 1'b0); // JAL
        cyc(r_ins(6'd34, 1, 2, 13),  1'b0, 1'b0, 1'b0, 1'b0, 1,  1'b1, 5'd13, 1'b0); // SUB
        cyc(i_ins(6'd63, 0, 0),      1'b0, 1'b0, 1'b0, 1'b0, 0,  1'b0, 5'd0,  1'b0); // STOP
        cyc(i_ins(6'd8, 1, 14),      1'b0, 1'b0, 1'b0, 1'b0, 0,  1'b0, 5'd0,  1'b0); // ADDI killed
        cyc(NOP,                     1'b0, 1'b0, 1'b0, 1'b0, 0,  1'b0, 5'd0,  1'b0);
        cyc(NOP,                     1'b0, 1'b0, 1'b0, 1'b0, 0,  1'b0, 5'd0,  1'b0);
        cyc(i_ins(6'd8, 1, 14),      1'b0, 1'b1, 1'b0, 1'b1, 0,  1'b0, 5'd0,  1'b0); // halted
        cyc(NOP,                     1'b0, 1'b1, 1'b0, 1'b1, 0,  1'b0, 5'd0,  1'b0);

        // Reset while halted with a branch pending: stall/flush read 0, state clears
        rst_n = 1'b0;
        drive(r_ins(6'd32, 1, 2, 3), 1'b1);
        #1;
        chk("rst_flush", 32'(bus.flush_ifid), 32'd0);
        chk("rst_stall", 32'(bus.stall),      32'd0);
        @(posedge clk);
        #1;
        drive(NOP, 1'b0);
        #1;
        chk("rst_halted", 32'(bus.halted),          32'd0);
        chk("rst_stall2", 32'(bus.stall),           32'd0);
        chk("rst_ex_alu", 32'(bus.ex_alu_ctrl),     32'd0);
        chk("rst_ex_dst", 32'(bus.ex_dst),          32'd0);
        chk("rst_memrd",  32'(bus.mem_read),        32'd0);
        chk("rst_memwr",  32'(bus.mem_write_en),    32'd0);
        chk("rst_wb_we",  32'(bus.wb_reg_write_en), 32'd0);
        chk("rst_wb_dst", 32'(bus.wb_dst),          32'd0);
        rst_n = 1'b1;
        prime();

        cyc(i_ins(6'd8, 1, 15),      1'b0, 1'b0, 1'b0, 1'b0, 0,  1'b1, 5'd15, 1'b0); // ADDI after reset
        cyc(i_ins(6'd14, 2, 16),     1'b0, 1'b0, 1'b0, 1'b0, 4,  1'b1, 5'd16, 1'b0); // XORI
        repeat (3)
            cyc(NOP,                 1'b0, 1'b0, 1'b0, 1'b0, 0,  1'b0, 5'd0,  1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe_hazard.md
Name: ctrl_pipe_hazard

Overview:
- Pipelined successor to the single-cycle main control decoder.
- Decodes opcode/func in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards (stall) and taken-branch hazards (flush), and latches a STOP halt.
- Sits between the IF/ID instruction register and the datapath pipeline registers of the pipeline CPU.

Parameters:
- ALUCTRL_W, 5, width of the ALU operation code.
- ALUSRC_W, 5, width of the ALU operand-source select.
- REG_W, 5, register address width.
- LOAD_STALL_EN, 1, 1 = insert a load-use bubble; 0 = never stall (forwarding-only builds).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_opcode  in  6  instr[31:26]
- id_func  in  6  instr[5:0]
- id_rs  in  REG_W  instr[25:21]
- id_rt  in  REG_W  instr[20:16]
- id_rd  in  REG_W  instr[15:11]
- ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle
- stall  out  1  hold PC and IF/ID this cycle
- flush_ifid  out  1  clear IF/ID next edge
- ex_alu_ctrl  out  ALUCTRL_W  EX ALU op
- ex_alu_src  out  ALUSRC_W  EX operand select
- ex_beq  out  1  EX-stage BEQ
- ex_bne  out  1  EX-stage BNE
- ex_jump  out  1  EX-stage J/JAL/JR
- ex_dst  out  REG_W  EX destination register
- mem_write_en  out  1  MEM-stage store
- mem_read  out  1  MEM-stage load
- wb_reg_write_en  out  1  WB register write
- wb_mem2reg  out  1  WB selects memory data
- wb_dst  out  REG_W  WB destination register
- illegal  out  1  ID opcode/func undefined (combinational)
- halted  out  1  STOP retired; sticky

Behaviour:
- Decode (combinational, ID):
  - R-type, opcode 0: func SLL0/SRL2/SRA3 give alu 7/8/9, src 4. SLLV4/SRLV6/SRAV7 give alu 7/8/9, src 3. ADD/ADDU give alu 0; SUB/SUBU alu 1; AND 2; OR 3; XOR 4; NOR 5; SLT 6; all with src 0. R-type uses dst=rd and write=1. JR8 sets jump=1 with write=0.
  - I/J-type by opcode:
    - BEQ4 and BNE5: alu 1, src 0, write 0.
    - ADDI8/ADDIU9: alu 0, src 2. ANDI12/ORI13/XORI14: alu 2/3/4, src 1. These write rt.
    - LW35: alu 0, src 2, read=1, mem2reg=1, write rt.
    - SW43: alu 0, src 2, mem_write=1.
    - J2: jump. JAL3: jump, write, dst=31.
    - STOP63: all controls 0, sets the stop marker.
  - Undefined encoding: all controls 0, illegal=1, treated as a bubble.
  - id_valid=0: bubble, illegal=0.
- Pipeline:
  - Each edge shifts ID→EX→MEM→WB; latency is 1 cycle per stage.
  - A bubble is all-zero controls with dst 0.
- Load-use stall:
  - Condition: stall=LOAD_STALL_EN & ex_mem_read & ex_dst≠0 & id_valid & (ex_dst==id_rs | (ex_dst==id_rt & ID uses rt as a source)).
  - rt is a source for R-type, BEQ/BNE and SW.
  - On stall, ID/EX loads a bubble; EX→MEM→WB still advance.
- Flush:
  - ex_branch_taken=1 → flush_ifid=1, ID/EX loads a bubble, stall forced 0.
  - Flush wins over a simultaneous stall.
- Halt:
  - Once STOP is decoded in ID, that STOP and all later ID instructions enter as bubbles, except a STOP killed by flush.
  - A STOP marker travels to WB; halted=1 the cycle after it leaves WB, and stays high until reset.
  - While halted, stall=1.
- Reset (rst_n=0 at an edge):
  - All stage registers are cleared to bubbles; halted=0 and the stop marker clears.
  - stall and flush_ifid read 0 during reset.
  - Reset mid-stall or mid-flush discards the in-flight instructions.
- No write to register 0: wb_reg_write_en is gated to 0 when wb_dst==0.

Test Plan:
- ADD rd=3 then ORI rt=4 -> ex_alu_ctrl 0 then 3. 2 cycles later wb_dst=3, wb_reg_write_en=1, then wb_dst=4.
- LW rt=5, then ADD rs=5 -> stall=1 for exactly 1 cycle; one bubble in EX; ADD reaches WB 1 cycle late.
- LW rt=0, then ADD rs=0 -> stall=0.
- BEQ in EX with ex_branch_taken=1 while ID holds LW-dependent ADD -> flush_ifid=1, stall=0, ID/EX is a bubble.
- Opcode 6'd20 -> illegal=1, no write reaches WB.
- JAL -> wb_dst=31 and wb_reg_write_en=1.
- STOP followed by ADDI -> ADDI never writes; halted rises 4 cycles after STOP enters ID and stays high; rst_n low for 1 edge -> halted=0 and all outputs 0.
